demux_rx_collector: RTL and testbench

//  Sits directly downstream of the 1:4 demux (demux_1_4). It samples the routed bit on y[sel]

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_rx_lane.sv | 67 ++++++
 rtl/demux_rx_collector.sv | 88 ++++++++
 tb/tb_demux_rx_collector.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux receive path: channel count, channel index type
// and the round-robin search used by the output arbiter.
package demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] chan_t;

    // First requesting channel at ptr+1, ptr+2, ... ptr (wrapping); returns ptr if none request.
    function automatic chan_t rr_next(input chan_t ptr, input logic [NCH-1:0] req);
        chan_t w_c;
        rr_next = ptr;
        for (int i = NCH; i >= 1; i--) begin
            w_c = ptr + chan_t'(i);
            if (req[w_c]) begin
                rr_next = w_c;
            end
        end
    endfunction

endpackage

// File: rtl/demux_rx_lane.sv
// One receive lane: LSB-first shift register, bit counter, single-word hold buffer
// and a sticky overflow flag for words that arrive while the hold buffer is busy.
module demux_rx_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit_en,
    input  logic             i_bit,
    input  logic             i_grant,
    input  logic             i_ovf_clr,
    output logic             o_hold_full,
    output logic [WIDTH-1:0] o_hold,
    output logic             o_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_ovf;

    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_accept;

    assign w_word   = {i_bit, r_sh[WIDTH-1:1]};
    assign w_done   = i_bit_en && (r_cnt == LAST);
    // A hold buffer being drained this cycle can take the new word at the same edge.
    assign w_accept = !r_hold_full || i_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh        <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (i_bit_en) begin
                r_sh  <= w_word;
                r_cnt <= w_done ? '0 : r_cnt + 1'b1;
            end

            if (w_done && w_accept) begin
                r_hold      <= w_word;
                r_hold_full <= 1'b1;
            end else if (i_grant) begin
                r_hold_full <= 1'b0;
            end

            if (w_done && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_hold_full = r_hold_full;
    assign o_hold      = r_hold;
    assign o_ovf       = r_ovf;

endmodule

// File: rtl/demux_rx_collector.sv
// Collects bits routed by a 1:4 demux into per-channel words and presents completed
// words on one valid/ready output, arbitrated round-robin across channels.
module demux_rx_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             bit_vld,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             ovf_clr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [1:0]       out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       ovf
);

    logic [NCH-1:0]   w_y;
    logic             w_bit;
    logic [NCH-1:0]   w_req;
    logic [NCH-1:0]   w_grant;
    logic [NCH-1:0]   w_ovf;
    logic [WIDTH-1:0] w_hold [NCH];
    logic             w_load;
    logic             w_gnt_any;
    chan_t            w_gnt_ch;

    logic             r_out_vld;
    chan_t            r_out_ch;
    logic [WIDTH-1:0] r_out_data;
    chan_t            r_ptr;

    assign w_y   = {y3, y2, y1, y0};
    assign w_bit = w_y[sel];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            demux_rx_lane #(.WIDTH(WIDTH)) u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_bit_en   (bit_vld && (sel == chan_t'(gi))),
                .i_bit      (w_bit),
                .i_grant    (w_grant[gi]),
                .i_ovf_clr  (ovf_clr),
                .o_hold_full(w_req[gi]),
                .o_hold     (w_hold[gi]),
                .o_ovf      (w_ovf[gi])
            );
            assign w_grant[gi] = w_gnt_any && (w_gnt_ch == chan_t'(gi));
        end
    endgenerate

    assign w_load    = !r_out_vld || out_rdy;
    assign w_gnt_ch  = rr_next(r_ptr, w_req);
    assign w_gnt_any = w_load && (|w_req);

    // Pointer resets to the last channel so channel 0 wins the first grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_ch   <= '0;
            r_out_data <= '0;
            r_ptr      <= chan_t'(NCH - 1);
        end else if (w_load) begin
            if (w_gnt_any) begin
                r_out_vld  <= 1'b1;
                r_out_ch   <= w_gnt_ch;
                r_out_data <= w_hold[w_gnt_ch];
                r_ptr      <= w_gnt_ch;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_ch   = r_out_ch;
    assign out_data = r_out_data;
    assign ovf      = w_ovf;

endmodule

// File: tb/tb_demux_rx_collector.sv
// Directed bench for demux_rx_collector: reset, single word, RR ordering, overflow,
// idle inputs and mid-word reset, each against hand-computed expectations.
module tb_demux_rx_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = '0;
    logic       bit_vld = 1'b0;
    logic       y0 = 1'b0, y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic [1:0] out_ch;
    logic [7:0] out_data;
    logic [3:0] ovf;

    int n_checks = 0;
    int n_fail   = 0;

    demux_rx_collector #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .bit_vld (bit_vld),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .ovf_clr (ovf_clr),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_ch  (out_ch),
        .out_data(out_data),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_y();
        {y3, y2, y1, y0} = 4'($urandom);
    endtask

    // Drive nbits LSB-first on channel ch, one bit per cycle, with noise on the other lanes.
    task automatic send_bits(input logic [1:0] ch, input logic [7:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rand_y();
            sel     = ch;
            bit_vld = 1'b1;
            case (ch)
                2'd0: y0 = data[i];
                2'd1: y1 = data[i];
                2'd2: y2 = data[i];
                default: y3 = data[i];
            endcase
            tick();
        end
        bit_vld = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [1:0] ch, input logic [7:0] data);
        check_val({tag, "_vld"}, 32'(out_vld), 32'd1);
        check_val({tag, "_ch"}, 32'(out_ch), 32'(ch));
        check_val({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rand_y();
            sel     = 2'($urandom);
            bit_vld = 1'($urandom);
            ovf_clr = 1'($urandom);
            out_rdy = 1'($urandom);
            tick();
        end
        check_val("rst_vld", 32'(out_vld), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_ch", 32'(out_ch), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0; bit_vld = 1'b0; ovf_clr = 1'b0; out_rdy = 1'b1;
        tick();

        // 2: single word on ch2, bits 1,0,1,0,0,1,0,1 -> 8'hA5
        send_bits(2'd2, 8'hA5, 8);
        check_val("t2_early_vld", 32'(out_vld), 32'd0);
        tick();
        check_out("t2", 2'd2, 8'hA5);
        tick();
        check_val("t2_one_cycle", 32'(out_vld), 32'd0);

        // 3: RR ordering with back-pressure
        out_rdy = 1'b0;
        send_bits(2'd0, 8'h11, 8);
        tick();
        send_bits(2'd1, 8'h22, 8);
        check_out("t3_w0", 2'd0, 8'h11);
        out_rdy = 1'b1;
        tick();
        check_out("t3_w1", 2'd1, 8'h22);
        out_rdy = 1'b0;
        send_bits(2'd1, 8'h33, 8);
        send_bits(2'd0, 8'h44, 8);
        check_out("t3_stall", 2'd1, 8'h22);
        out_rdy = 1'b1;
        tick();
        check_out("t3_rr0", 2'd0, 8'h44);
        tick();
        check_out("t3_rr1", 2'd1, 8'h33);
        tick();
        check_val("t3_empty", 32'(out_vld), 32'd0);
        check_val("t3_ovf", 32'(ovf), 32'd0);

        // 4: overflow on ch3
        out_rdy = 1'b0;
        send_bits(2'd3, 8'h81, 8);
        send_bits(2'd3, 8'h82, 8);
        check_val("t4_ovf_none", 32'(ovf), 32'd0);
        send_bits(2'd3, 8'h83, 8);
        check_val("t4_ovf_set", 32'(ovf), 32'b1000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("t4_ovf_clr", 32'(ovf), 32'd0);
        check_out("t4_w1", 2'd3, 8'h81);
        out_rdy = 1'b1;
        tick();
        check_out("t4_w2", 2'd3, 8'h82);
        tick();
        check_val("t4_empty", 32'(out_vld), 32'd0);

        // 5: idle with noise on sel and y
        for (int i = 0; i < 20; i++) begin
            rand_y();
            sel = 2'($urandom);
            tick();
            check_val($sformatf("t5_idle%0d", i), 32'(out_vld), 32'd0);
        end
        send_bits(2'd1, 8'h5A, 8);
        tick();
        check_out("t5", 2'd1, 8'h5A);
        tick();

        // 6: reset mid-word discards the partial word
        send_bits(2'd1, 8'hFF, 5);
        rst = 1'b1;
        tick();
        check_val("t6_rst_vld", 32'(out_vld), 32'd0);
        rst = 1'b0;
        tick();
        send_bits(2'd1, 8'h3C, 8);
        tick();
        check_out("t6", 2'd1, 8'h3C);
        tick();
        check_val("t6_single", 32'(out_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
